// File: rtl/cache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cache_pkg
// Description : Shared definitions for the cache-to-RAM line interface.
//               Holds the default line/address/latency constants used by the
//               cache data arrays and the RAM responder, the responder state
//               encoding, and helpers deriving the line offset and index
//               widths from the line size and storage depth.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package cache_pkg;

    localparam int c_addr_w = 32;   // byte address width
    localparam int c_line_w = 128;  // cache line width in bits
    localparam int c_lat    = 4;    // RAM access latency in cycles

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } ram_state_t;

    // Number of byte-offset bits inside one line.
    function automatic int line_off_bits(input int line_w);
        return $clog2(line_w / 8);
    endfunction

    // Number of line-index bits for a storage of the given depth.
    function automatic int line_idx_bits(input int depth_lines);
        return $clog2(depth_lines);
    endfunction

endpackage : cache_pkg
`default_nettype wire

// File: rtl/ram_line_array.sv
`default_nettype none
// ============================================================================
// Module      : ram_line_array
// Description : Line-organised storage, DEPTH_LINES x LINE_W.
//               Synchronous write, combinational read. Contents not reset.
// Ports       : clk      - clock
//               wr_en    - write strobe
//               wr_idx   - line index to write
//               wr_data  - line data to write
//               rd_idx   - line index to read
//               rd_data  - line data at rd_idx (combinational)
// Revision    : 1.0 - initial release
// ============================================================================
module ram_line_array #(
    parameter int LINE_W      = 128,
    parameter int DEPTH_LINES = 256
) (
    input  logic                           clk,
    input  logic                           wr_en,
    input  logic [$clog2(DEPTH_LINES)-1:0] wr_idx,
    input  logic [LINE_W-1:0]              wr_data,
    input  logic [$clog2(DEPTH_LINES)-1:0] rd_idx,
    output logic [LINE_W-1:0]              rd_data
);

    logic [LINE_W-1:0] r_mem [DEPTH_LINES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_idx] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_idx];

endmodule : ram_line_array
`default_nettype wire

// File: rtl/ram_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : ram_line_responder
// Description : RAM-side responder for cache line refills and writebacks.
//               Accepts one line request in IDLE, waits LAT cycles in total,
//               then pulses response for one cycle with read data (0 for a
//               write). Writes commit to storage at the sampling edge.
// Ports       : clk                   - clock
//               rst                   - asynchronous active-low reset
//               enable_cache_to_ram   - request valid (level)
//               write_cache_to_ram    - 1 = line write, 0 = line read
//               addr_cache_to_ram     - byte address (offset bits ignored)
//               wdata_cache_to_ram    - writeback line data
//               rdata_ram_to_cache    - read line data, valid with response
//               response_ram_to_cache - single-cycle completion pulse
//               busy_ram              - high while a request is in flight
//               err_ram_to_cache      - out-of-range flag with response
//                                       (only with RAM_LINE_RESPONDER_ERR_EN)
// Options     : RAM_LINE_RESPONDER_ERR_EN - adds out-of-range detection; an
//               out-of-range write is dropped and a read returns 0.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_line_responder
    import cache_pkg::*;
#(
    parameter int ADDR_W      = c_addr_w,
    parameter int LINE_W      = c_line_w,
    parameter int DEPTH_LINES = 256,
    parameter int LAT         = c_lat
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable_cache_to_ram,
    input  logic              write_cache_to_ram,
    input  logic [ADDR_W-1:0] addr_cache_to_ram,
    input  logic [LINE_W-1:0] wdata_cache_to_ram,
    output logic [LINE_W-1:0] rdata_ram_to_cache,
    output logic              response_ram_to_cache,
    output logic              busy_ram
`ifdef RAM_LINE_RESPONDER_ERR_EN
    ,
    output logic              err_ram_to_cache
`endif
);

    localparam int c_off   = line_off_bits(LINE_W);
    localparam int c_idx   = line_idx_bits(DEPTH_LINES);
    // Countdown only ever holds LAT-2 down to 0.
    localparam int c_cnt_w = (LAT > 2) ? $clog2(LAT - 1) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_load = c_cnt_w'((LAT >= 2) ? (LAT - 2) : 0);

    ram_state_t         r_state, w_state_nxt;
    logic [c_cnt_w-1:0] r_cnt, w_cnt_nxt;
    logic               r_write, w_write_nxt;
    logic [c_idx-1:0]   r_idx, w_idx_nxt;
    logic               r_oor, w_oor_nxt;
    logic [LINE_W-1:0]  r_rdata, w_rdata_nxt;
    logic               r_resp, w_resp_nxt;
    logic               r_busy, w_busy_nxt;

    logic [c_idx-1:0]   w_req_idx;
    logic               w_req_oor;
    logic [c_idx-1:0]   w_rd_idx;
    logic               w_we;
    logic [LINE_W-1:0]  w_array_rdata;
    logic               w_unused_addr;

    assign w_req_idx     = addr_cache_to_ram[c_off+c_idx-1:c_off];
    // Offset bits (and aliasing upper bits) are deliberately not decoded.
    assign w_unused_addr = ^addr_cache_to_ram;

`ifdef RAM_LINE_RESPONDER_ERR_EN
    generate
        if (c_off + c_idx < ADDR_W) begin : g_oor_check
            assign w_req_oor = |addr_cache_to_ram[ADDR_W-1:c_off+c_idx];
        end else begin : g_oor_none
            assign w_req_oor = 1'b0;
        end
    endgenerate
`else
    assign w_req_oor = 1'b0;
`endif

    // In IDLE the array is read with the incoming index so that LAT=1 can
    // load rdata at the sampling edge; otherwise use the latched index.
    assign w_rd_idx = (r_state == ST_IDLE) ? w_req_idx : r_idx;
    assign w_we     = (r_state == ST_IDLE) && enable_cache_to_ram &&
                      write_cache_to_ram && !w_req_oor;

    ram_line_array #(
        .LINE_W      (LINE_W),
        .DEPTH_LINES (DEPTH_LINES)
    ) u_array (
        .clk     (clk),
        .wr_en   (w_we),
        .wr_idx  (w_req_idx),
        .wr_data (wdata_cache_to_ram),
        .rd_idx  (w_rd_idx),
        .rd_data (w_array_rdata)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_write <= 1'b0;
            r_idx   <= '0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
            r_resp  <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_write <= w_write_nxt;
            r_idx   <= w_idx_nxt;
            r_oor   <= w_oor_nxt;
            r_rdata <= w_rdata_nxt;
            r_resp  <= w_resp_nxt;
            r_busy  <= w_busy_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_write_nxt = r_write;
        w_idx_nxt   = r_idx;
        w_oor_nxt   = r_oor;
        w_rdata_nxt = r_rdata;
        w_resp_nxt  = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                if (enable_cache_to_ram) begin
                    w_write_nxt = write_cache_to_ram;
                    w_idx_nxt   = w_req_idx;
                    w_oor_nxt   = w_req_oor;
                    if (LAT == 1) begin
                        w_state_nxt = ST_RESP;
                        w_resp_nxt  = 1'b1;
                        w_rdata_nxt = (write_cache_to_ram || w_req_oor) ? '0 : w_array_rdata;
                    end else begin
                        w_state_nxt = ST_BUSY;
                        w_cnt_nxt   = c_cnt_load;
                    end
                end
            end
            ST_BUSY: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                    w_resp_nxt  = 1'b1;
                    w_rdata_nxt = (r_write || r_oor) ? '0 : w_array_rdata;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    assign rdata_ram_to_cache    = r_rdata;
    assign response_ram_to_cache = r_resp;
    assign busy_ram              = r_busy;

`ifdef RAM_LINE_RESPONDER_ERR_EN
    logic r_err;

    // w_oor_nxt always carries the flag of the request that is completing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_resp_nxt && w_oor_nxt;
        end
    end

    assign err_ram_to_cache = r_err;
`endif

endmodule : ram_line_responder
`default_nettype wire

// File: tb/tb_ram_line_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_line_responder
// Description : Self-checking bench for ram_line_responder. A LAT=4 instance
//               is exercised with a vector table, hand-written multi-cycle
//               sequences and random traffic against a line-array model; a
//               LAT=1 instance covers the minimum-latency path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_line_responder;

    localparam int c_tb_lat = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         en, wr;
    logic [31:0]  addr;
    logic [127:0] wdata;
    logic [127:0] rdata;
    logic         resp, busy;

    logic         en1, wr1;
    logic [31:0]  addr1;
    logic [127:0] wdata1;
    logic [127:0] rdata1;
    logic         resp1, busy1;
`ifdef RAM_LINE_RESPONDER_ERR_EN
    logic         err, err1;
`endif

    always #5 clk = ~clk;

    ram_line_responder #(
        .ADDR_W(32), .LINE_W(128), .DEPTH_LINES(256), .LAT(c_tb_lat)
    ) u_dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable_cache_to_ram   (en),
        .write_cache_to_ram    (wr),
        .addr_cache_to_ram     (addr),
        .wdata_cache_to_ram    (wdata),
        .rdata_ram_to_cache    (rdata),
        .response_ram_to_cache (resp),
        .busy_ram              (busy)
`ifdef RAM_LINE_RESPONDER_ERR_EN
        ,
        .err_ram_to_cache      (err)
`endif
    );

    ram_line_responder #(
        .ADDR_W(32), .LINE_W(128), .DEPTH_LINES(256), .LAT(1)
    ) u_dut_lat1 (
        .clk                   (clk),
        .rst                   (rst),
        .enable_cache_to_ram   (en1),
        .write_cache_to_ram    (wr1),
        .addr_cache_to_ram     (addr1),
        .wdata_cache_to_ram    (wdata1),
        .rdata_ram_to_cache    (rdata1),
        .response_ram_to_cache (resp1),
        .busy_ram              (busy1)
`ifdef RAM_LINE_RESPONDER_ERR_EN
        ,
        .err_ram_to_cache      (err1)
`endif
    );

    int vectors    = 0;
    int miscompares = 0;

    // Reference storage: one entry per line, indexed by byte address / 16.
    logic [127:0] model [256];

    typedef struct {
        logic         w;
        logic [31:0]  a;
        logic [127:0] d;
        logic [127:0] exp;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a / 32'd16) % 32'd256);
    endfunction

    function automatic bit oor_of(input logic [31:0] a);
`ifdef RAM_LINE_RESPONDER_ERR_EN
        return (a / 32'd4096) != 32'd0;
`else
        return (a == 32'hFFFF_FFFF) && 1'b0;
`endif
    endfunction

    function automatic logic [127:0] rnd_line();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // One isolated request: enable for a single sampling edge, then garbage
    // on the inputs while the request is in flight.
    task automatic txn(input logic w, input logic [31:0] a, input logic [127:0] d,
                       input logic [127:0] exp, input string name);
        bit early;
        early = 1'b0;
        @(negedge clk);
        en = 1'b1; wr = w; addr = a; wdata = d;
        @(posedge clk); #1;
        en = 1'b0; wr = 1'($urandom); addr = $urandom; wdata = rnd_line();
        check({name, " busy"}, 128'(busy), 128'd1);
        for (int i = 1; i < c_tb_lat; i++) begin
            @(posedge clk); #1;
            if (i < c_tb_lat - 1 && resp) early = 1'b1;
        end
        check({name, " early"}, 128'(early), 128'd0);
        check({name, " resp"}, 128'(resp), 128'd1);
        check({name, " rdata"}, rdata, exp);
`ifdef RAM_LINE_RESPONDER_ERR_EN
        check({name, " err"}, 128'(err), 128'(oor_of(a)));
`endif
        @(posedge clk); #1;
        check({name, " done"}, 128'({resp, busy}), 128'd0);
        if (w && !oor_of(a)) model[idx_of(a)] = d;
    endtask

    initial begin
        logic [127:0] line_a, line_b, line_c, line_d, got_rd;
        int           p0, p1, npulse;
        logic         w;
        logic [31:0]  a;
        logic [127:0] d;

        line_a = 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D;
        line_b = 128'h11112222_33334444_55556666_77778888;
        line_c = 128'hA5A5A5A5_5A5A5A5A_0F0F0F0F_F0F0F0F0;
        line_d = 128'h0BADF00D_12345678_9ABCDEF0_FEEDFACE;

        rst = 1'b0; en = 1'b0; wr = 1'b0; addr = '0; wdata = '0;
        en1 = 1'b0; wr1 = 1'b0; addr1 = '0; wdata1 = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset rdata", rdata, 128'd0);
        check("reset resp/busy", 128'({resp, busy}), 128'd0);
        check("reset lat1", 128'({rdata1 != 128'd0, resp1, busy1}), 128'd0);
        @(negedge clk);
        rst = 1'b1;

        // Table-driven vectors
        tbl[0] = '{1'b1, 32'h0000_0040, line_a, 128'd0};
        tbl[1] = '{1'b0, 32'h0000_0040, 128'd0, line_a};
        tbl[2] = '{1'b1, 32'h0000_0080, line_b, 128'd0};
        tbl[3] = '{1'b1, 32'h0000_0100, line_c, 128'd0};
        tbl[4] = '{1'b0, 32'h0000_0100, 128'd0, line_c};
        tbl[5] = '{1'b0, 32'h0000_0080, 128'd0, line_b};
        tbl[6] = '{1'b1, 32'h0000_004C, line_d, 128'd0};
        tbl[7] = '{1'b0, 32'h0000_0047, 128'd0, line_d};
        for (int i = 0; i < 8; i++) begin
            txn(tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].exp, $sformatf("tbl%0d", i));
        end

        // Back-to-back: writeback 0x80 then refill 0x100, enable held high
        @(negedge clk);
        en = 1'b1; wr = 1'b1; addr = 32'h80; wdata = line_a;
        @(posedge clk); #1;
        wr = 1'b0; addr = 32'h100; wdata = '0;
        p0 = -1; p1 = -1; npulse = 0; got_rd = '0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk); #1;
            if (resp) begin
                npulse++;
                if (p0 < 0) p0 = c;
                else begin p1 = c; got_rd = rdata; end
            end
            if (c == 5) en = 1'b0;
        end
        model[8] = line_a;
        check("b2b pulses", 128'(npulse), 128'd2);
        check("b2b first", 128'(p0), 128'd3);
        check("b2b second", 128'(p1), 128'd8);
        check("b2b rdata", got_rd, model[16]);
        txn(1'b0, 32'h80, '0, line_a, "b2b wb check");

        // Enable dropped and inputs changed during BUSY
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 32'h40; wdata = '0;
        @(posedge clk); #1;
        en = 1'b0; wr = 1'b1; addr = 32'h80; wdata = line_c;
        p0 = -1; npulse = 0; got_rd = '0;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk); #1;
            if (resp) begin npulse++; p0 = c; got_rd = rdata; end
        end
        check("drop pulses", 128'(npulse), 128'd1);
        check("drop time", 128'(p0), 128'd3);
        check("drop rdata", got_rd, model[4]);
        txn(1'b0, 32'h80, '0, model[8], "drop no write");

        // Reset two cycles after a read is sampled
        @(negedge clk);
        en = 1'b1; wr = 1'b0; addr = 32'h100;
        @(posedge clk); #1;
        en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("rst outputs", 128'({resp, busy}), 128'd0);
        check("rst rdata", rdata, 128'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        npulse = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (resp || busy) npulse++;
        end
        check("rst no pulse", 128'(npulse), 128'd0);
        txn(1'b0, 32'h100, '0, model[16], "post rst read");

        // LAT=1 instance: write 0x10, then read it sampled in the next IDLE
        @(negedge clk);
        en1 = 1'b1; wr1 = 1'b1; addr1 = 32'h10; wdata1 = line_b;
        @(posedge clk); #1;
        check("lat1 resp0", 128'({resp1, busy1}), 128'd3);
        check("lat1 wr rdata", rdata1, 128'd0);
        wr1 = 1'b0; wdata1 = '0;
        @(posedge clk); #1;
        check("lat1 idle", 128'({resp1, busy1}), 128'd0);
        @(posedge clk); #1;
        en1 = 1'b0;
        check("lat1 resp2", 128'(resp1), 128'd1);
        check("lat1 rd rdata", rdata1, line_b);
        @(posedge clk); #1;
        check("lat1 end", 128'({resp1, busy1}), 128'd0);

        // Fill every line so random reads have known contents
        for (int i = 0; i < 256; i++) begin
            txn(1'b1, 32'(i * 16), rnd_line(), 128'd0, "fill");
        end

`ifdef RAM_LINE_RESPONDER_ERR_EN
        txn(1'b1, 32'h0000_1000, line_c, 128'd0, "err write");
        txn(1'b0, 32'h0000_1000, '0, 128'd0, "err read");
        txn(1'b0, 32'h0000_0000, '0, model[0], "err clean");
`else
        txn(1'b0, 32'hFFFF_F040, '0, model[4], "alias read");
`endif

        // Random traffic against the model
        for (int i = 0; i < 250; i++) begin
            w = 1'($urandom);
            a = $urandom;
`ifdef RAM_LINE_RESPONDER_ERR_EN
            if ($urandom_range(0, 7) != 0) a = a & 32'h0000_0FFF;
`endif
            d = rnd_line();
            txn(w, a, d, (w || oor_of(a)) ? 128'd0 : model[idx_of(a)], "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_ram_line_responder
`default_nettype wire

// File: doc/ram_line_responder.md
Name: ram_line_responder

Overview:
- RAM-side responder for the cache-to-RAM line interface driven by the cache control FSMs.
- Accepts one line read or line write per request, holds it for a fixed access latency, then returns a single-cycle response with read data.
- Serves both I-cache and D-cache refills and D-cache dirty writebacks; backed by an internal line-organised storage array.

Parameters:
- ADDR_W, 32, byte address width.
- LINE_W, 128, cache line width in bits; power of two, at least 32.
- DEPTH_LINES, 256, lines of storage; power of two.
- LAT, 4, access latency in cycles; must be at least 1.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- enable_cache_to_ram  in  1  request valid, level, held by the requester until it sees the response.
- write_cache_to_ram  in  1  1 = line write (writeback), 0 = line read (refill); sampled with the request.
- addr_cache_to_ram  in  ADDR_W  line address; offset bits are ignored.
- wdata_cache_to_ram  in  LINE_W  writeback line data.
- rdata_ram_to_cache  out  LINE_W  read line data; valid only while the response is high.
- response_ram_to_cache  out  1  single-cycle completion pulse.
- busy_ram  out  1  high in BUSY and RESP.

Behaviour:
- Reset values: rdata 0, response 0, busy 0, state IDLE. Storage contents are not reset.
- Indexing:
  - OFF = log2(LINE_W/8).
  - IDX = log2(DEPTH_LINES).
  - Line index = addr[OFF+IDX-1:OFF]. Upper bits are ignored and alias.
- FSM with registered outputs; states IDLE, BUSY, RESP.
- IDLE:
  - If enable=1 at a rising edge, latch write, index and wdata.
  - A write commits to storage at this same edge.
  - Next state is RESP if LAT=1, else BUSY with the countdown loaded to LAT-2.
- BUSY:
  - Decrement the countdown each cycle.
  - At zero, go to RESP and load rdata: storage[index] for a read, 0 for a write.
- RESP:
  - response=1 for exactly one cycle, then go to IDLE unconditionally.
- Latency: if the request is sampled at edge k, response is high in the cycle after edge k+LAT-1, i.e. LAT cycles after sampling.
- Back-to-back requests:
  - The requester may keep enable high across consecutive requests, e.g. writeback followed by refill.
  - The cycle after RESP is IDLE. If enable is still 1 there, it is sampled as a new request with the current write and addr values.
  - Minimum request-to-request spacing is LAT+1 cycles.
- Enable or write changing, or enable dropping, during BUSY or RESP: ignored. The latched request completes and still pulses response.
- Read after write to the same line returns the written data.
- Reset asserted mid-operation:
  - Immediately returns to IDLE with response=0; no pulse is issued.
  - A write already sampled stays committed.
- rdata holds its value outside RESP.

Optional Feature:
- Macro: RAM_LINE_RESPONDER_ERR_EN.
- When defined:
  - Adds output port err_ram_to_cache (1 bit).
  - Any set address bit at position OFF+IDX or above flags the request out-of-range.
  - An out-of-range write is not committed; an out-of-range read returns rdata 0.
  - err is high in the same cycle as response, otherwise 0; reset value 0.
- When undefined: no err port, and upper address bits alias as described above.

Decomposition:
- Shared package cache_pkg:
  - state enum for IDLE/BUSY/RESP;
  - OFF and IDX derivation functions;
  - default LINE_W, ADDR_W and LAT constants, shared with the cache data arrays.
- One sub-module, ram_line_array:
  - DEPTH_LINES x LINE_W storage;
  - synchronous write, combinational read;
  - parameters LINE_W and DEPTH_LINES.

Test Plan:
- LAT=4: write addr 0x00000040, wdata 0xDEADBEEF_01234567_89ABCDEF_CAFEF00D; then read 0x00000040 -> each response is a single pulse 4 cycles after sampling, and the read returns the written line.
- Writeback to 0x80 then refill from 0x100 with enable held high throughout -> two pulses 5 cycles apart; storage[8] updated; the read returns storage[16].
- Read 0x40 sampled, then enable dropped and addr changed to 0x80 during BUSY -> pulse still arrives on time, with line 4 data.
- Reset asserted 2 cycles after a read is sampled -> response, busy and rdata read 0; no pulse after release; a fresh request completes normally.
- LAT=1 build: read 0x10 -> response in the cycle right after sampling; a second request sampled in the following IDLE cycle.
- ERR_EN build, DEPTH_LINES=256, LINE_W=128: write to 0x00001000 -> err=1 with response, no storage write; a read of 0x00001000 returns 0 with err=1; a read of 0x0 afterwards returns unchanged data with err=0.
